// File: rtl/vecmac_mul_sched_if.sv
// rtl/vecmac_mul_sched_if.sv - operand stream, result stream and multiplier handshake bundle
// The scheduler takes the slave view; the environment (stream source, sink, multiplier) the master view.
interface vecmac_mul_sched_if #(
   parameter int ACC_W = 24
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;
   logic             out_err;
   logic             mul_start;
   logic [3:0]       mul_a;
   logic [3:0]       mul_b;
   logic [7:0]       mul_o;
   logic             mul_finish;
   logic             busy;

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready, mul_o, mul_finish,
      output in_ready, out_valid, out_sum, out_ovf, out_err, mul_start, mul_a, mul_b, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready, mul_o, mul_finish,
      input  in_ready, out_valid, out_sum, out_ovf, out_err, mul_start, mul_a, mul_b, busy
   );
endinterface

// File: rtl/vecmac_mul_sched.sv
// rtl/vecmac_mul_sched.sv - signed int8 dot-product sequencer over one shared 4x4 self-timed multiplier
// Each pair is split into four nibble products; sign is applied once per pair on the magnitude sum.
module vecmac_mul_sched #(
   parameter int ACC_W       = 24,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic              clk,
   input  logic              reset,
   vecmac_mul_sched_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, ACCUM, OUT} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] fin_sync;
   logic                   fin_s;
   logic [7:0]             ma, mb;
   logic                   neg, last;
   logic [1:0]             k;
   logic [15:0]            pp, pp_add;
   logic [3:0]             shift;
   logic [ACC_W-1:0]       acc, contrib, acc_sum;
   logic                   ovf, err, ovf_now;
   logic [TW-1:0]          tmo;
   logic                   tmo_hit, accept, out_hs;
   logic                   in_ready_r, out_valid_r, mul_start_r;
   logic [3:0]             mul_a_r, mul_b_r;

   function automatic logic [7:0] mag(input logic [7:0] v);
      return v[7] ? (~v + 8'd1) : v;
   endfunction

   assign fin_s   = fin_sync[SYNC_STAGES-1];
   assign accept  = bus.in_valid && in_ready_r;
   assign out_hs  = out_valid_r && bus.out_ready;
   assign tmo_hit = (tmo == TMO_LAST);
   assign shift   = (k == 2'd0) ? 4'd0 : (k == 2'd3) ? 4'd8 : 4'd4;
   assign pp_add  = {8'd0, bus.mul_o} << shift;
   assign contrib = neg ? (~{{(ACC_W-16){1'b0}}, pp} + 1'b1) : {{(ACC_W-16){1'b0}}, pp};
   assign acc_sum = acc + contrib;
   assign ovf_now = (acc[ACC_W-1] == contrib[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = LOAD;
         LOAD:    state_n = ISSUE;
         ISSUE:   state_n = WAIT_HI;
         WAIT_HI: if (fin_s || tmo_hit) state_n = WAIT_LO;
         // A finish stuck high past the timeout abandons the remaining nibbles.
         WAIT_LO: begin
            if (!fin_s)       state_n = (k == 2'd3) ? ACCUM : ISSUE;
            else if (tmo_hit) state_n = ACCUM;
         end
         ACCUM:   state_n = last ? OUT : IDLE;
         OUT:     if (out_hs) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fin_sync    <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         mul_start_r <= 1'b0;
         mul_a_r     <= 4'd0;
         mul_b_r     <= 4'd0;
         tmo         <= '0;
         ma          <= 8'd0;
         mb          <= 8'd0;
         neg         <= 1'b0;
         last        <= 1'b0;
         k           <= 2'd0;
         pp          <= 16'd0;
         acc         <= '0;
         ovf         <= 1'b0;
         err         <= 1'b0;
      end else begin
         fin_sync    <= {fin_sync[SYNC_STAGES-2:0], bus.mul_finish};
         // Handshake outputs are decoded from the next state so they leave flops directly.
         in_ready_r  <= (state_n == IDLE);
         out_valid_r <= (state_n == OUT);
         mul_start_r <= (state_n == WAIT_HI);
         tmo         <= (state_n != state) ? '0 : tmo + 1'b1;
         case (state)
            IDLE: if (accept) begin
               ma   <= mag(bus.in_a);
               mb   <= mag(bus.in_b);
               neg  <= bus.in_a[7] ^ bus.in_b[7];
               last <= bus.in_last;
            end
            LOAD: begin
               k  <= 2'd0;
               pp <= 16'd0;
            end
            ISSUE: begin
               mul_a_r <= k[1] ? ma[7:4] : ma[3:0];
               mul_b_r <= k[0] ? mb[7:4] : mb[3:0];
            end
            WAIT_HI: begin
               if (fin_s)        pp  <= pp + pp_add;
               else if (tmo_hit) err <= 1'b1;
            end
            WAIT_LO: begin
               if (!fin_s) begin
                  if (k != 2'd3) k <= k + 2'd1;
               end else if (tmo_hit) begin
                  err <= 1'b1;
               end
            end
            ACCUM: begin
               acc <= acc_sum;
               pp  <= 16'd0;
               if (ovf_now) ovf <= 1'b1;
            end
            OUT: if (out_hs) begin
               acc <= '0;
               ovf <= 1'b0;
               err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = acc;
   assign bus.out_ovf   = ovf;
   assign bus.out_err   = err;
   assign bus.mul_start = mul_start_r;
   assign bus.mul_a     = mul_a_r;
   assign bus.mul_b     = mul_b_r;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_vecmac_mul_sched.sv
// tb/tb_vecmac_mul_sched.sv - directed bench for vecmac_mul_sched, two accumulator widths in lockstep
// A 24-bit and a 17-bit instance share stimulus; each has its own behavioural multiplier.
module tb_vecmac_mul_sched;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = 8'd0;
   logic [7:0] in_b = 8'd0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       hang = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         starts = 0;

   logic        f1, f2;
   logic [7:0]  o1, o2;
   int          d1, d2;

   logic [23:0] r_sum1;
   logic        r_ovf1, r_err1;
   logic [16:0] r_sum2;
   logic        r_ovf2;

   vecmac_mul_sched_if #(.ACC_W(24)) m1 ();
   vecmac_mul_sched_if #(.ACC_W(17)) m2 ();

   vecmac_mul_sched #(.ACC_W(24), .SYNC_STAGES(2), .TIMEOUT(1023)) dut1 (.clk(clk), .reset(reset), .bus(m1.slave));
   vecmac_mul_sched #(.ACC_W(17), .SYNC_STAGES(2), .TIMEOUT(1023)) dut2 (.clk(clk), .reset(reset), .bus(m2.slave));

   assign m1.in_valid = in_valid;  assign m2.in_valid = in_valid;
   assign m1.in_a = in_a;          assign m2.in_a = in_a;
   assign m1.in_b = in_b;          assign m2.in_b = in_b;
   assign m1.in_last = in_last;    assign m2.in_last = in_last;
   assign m1.out_ready = out_ready; assign m2.out_ready = out_ready;
   assign m1.mul_finish = f1;      assign m1.mul_o = o1;
   assign m2.mul_finish = f2;      assign m2.mul_o = o2;

   always #5 clk = ~clk;

   always @(posedge m1.mul_start) starts = starts + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         f1 <= 1'b0; o1 <= 8'd0; d1 <= 0;
      end else if (m1.mul_start && !f1 && !hang) begin
         if (d1 == 3) begin o1 <= {4'd0, m1.mul_a} * {4'd0, m1.mul_b}; f1 <= 1'b1; d1 <= 0; end
         else d1 <= d1 + 1;
      end else if (!m1.mul_start && f1) begin
         if (d1 == 2) begin f1 <= 1'b0; d1 <= 0; end
         else d1 <= d1 + 1;
      end else d1 <= 0;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         f2 <= 1'b0; o2 <= 8'd0; d2 <= 0;
      end else if (m2.mul_start && !f2 && !hang) begin
         if (d2 == 3) begin o2 <= {4'd0, m2.mul_a} * {4'd0, m2.mul_b}; f2 <= 1'b1; d2 <= 0; end
         else d2 <= d2 + 1;
      end else if (!m2.mul_start && f2) begin
         if (d2 == 2) begin f2 <= 1'b0; d2 <= 0; end
         else d2 <= d2 + 1;
      end else d2 <= 0;
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      while (!m1.in_ready && n < 10000) begin @(negedge clk); n++; end
      checks++;
      if (n >= 10000) begin errors++; $display("FAIL send_accept: in_ready never rose, required 1"); end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic get_result();
      int n = 0;
      @(negedge clk);
      while (!m1.out_valid && n < 8000) begin @(negedge clk); n++; end
      checks++;
      if (n >= 8000) begin errors++; $display("FAIL out_valid_wait: out_valid=%0b after %0d cycles, required 1", m1.out_valid, n); end
      r_sum1 = m1.out_sum; r_ovf1 = m1.out_ovf; r_err1 = m1.out_err;
      r_sum2 = m2.out_sum; r_ovf2 = m2.out_ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_sum(input string name, input logic [23:0] exp_sum, input logic exp_ovf, input logic exp_err);
      checks++;
      if (r_sum1 !== exp_sum || r_ovf1 !== exp_ovf || r_err1 !== exp_err) begin
         errors++;
         $display("FAIL %s: sum=%0d ovf=%0b err=%0b, required sum=%0d ovf=%0b err=%0b",
                  name, $signed(r_sum1), r_ovf1, r_err1, $signed(exp_sum), exp_ovf, exp_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (m1.in_ready !== 1'b0 || m1.out_valid !== 1'b0 || m1.mul_start !== 1'b0 || m1.busy !== 1'b0 || m1.out_sum !== 24'd0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%0b vld=%0b start=%0b busy=%0b sum=%0d, required all 0",
                  m1.in_ready, m1.out_valid, m1.mul_start, m1.busy, m1.out_sum);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (m1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: in_ready=%0b, required 1", m1.in_ready); end
   endtask

   task automatic test_single();
      int s0 = starts;
      send(8'd3, 8'd5, 1'b1);
      get_result();
      check_sum("single_3x5", 24'd15, 1'b0, 1'b0);
      checks++;
      if (starts - s0 !== 4) begin errors++; $display("FAIL start_pulses: got %0d, required 4", starts - s0); end
   endtask

   task automatic test_extremes();
      send(8'h80, 8'h80, 1'b1); get_result(); check_sum("m128_m128", 24'd16384, 1'b0, 1'b0);
      send(8'h80, 8'h7F, 1'b1); get_result(); check_sum("m128_127", -24'sd16256, 1'b0, 1'b0);
      send(8'h00, 8'hF9, 1'b1); get_result(); check_sum("zero_m7", 24'd0, 1'b0, 1'b0);
   endtask

   task automatic test_vector();
      send(8'd10, 8'd20, 1'b0);
      send(8'hFD, 8'd7, 1'b0);
      send(8'd127, 8'hFF, 1'b1);
      get_result(); check_sum("vector3", 24'd52, 1'b0, 1'b0);
      send(8'd2, 8'd2, 1'b1); get_result(); check_sum("acc_cleared", 24'd4, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back_hold();
      int n = 0;
      logic [23:0] held;
      logic bad = 1'b0;
      send(8'hFA, 8'd9, 1'b1);
      @(negedge clk);
      while (!m1.out_valid && n < 8000) begin @(negedge clk); n++; end
      held = m1.out_sum;
      checks++;
      if (held !== -24'sd54) begin errors++; $display("FAIL hold_value: sum=%0d, required -54", $signed(held)); end
      for (int i = 0; i < 50; i++) begin
         if (m1.out_valid !== 1'b1 || m1.out_sum !== held || m1.in_ready !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin errors++; $display("FAIL hold_stable: output changed or in_ready rose while stalled, required stable"); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (m1.in_ready !== 1'b1 || m1.out_valid !== 1'b0) begin
         errors++; $display("FAIL hold_release: in_ready=%0b out_valid=%0b, required 1 0", m1.in_ready, m1.out_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) send(8'd127, 8'd127, (i == 4));
      get_result();
      check_sum("wide_no_ovf", 24'd80645, 1'b0, 1'b0);
      checks++;
      if (r_sum2 !== 17'h13B05 || r_ovf2 !== 1'b1) begin
         errors++; $display("FAIL narrow_ovf: sum=%0h ovf=%0b, required sum=13b05 ovf=1", r_sum2, r_ovf2);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      send(8'd3, 8'd5, 1'b1);
      while (!m1.mul_start && n < 50) begin @(negedge clk); n++; end
      reset = 1'b1;
      #1;
      checks++;
      if (m1.mul_start !== 1'b0 || m1.busy !== 1'b0 || m1.in_ready !== 1'b0 || m1.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid: start=%0b busy=%0b rdy=%0b vld=%0b, required all 0",
                            m1.mul_start, m1.busy, m1.in_ready, m1.out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      send(8'd2, 8'd3, 1'b1); get_result(); check_sum("after_reset", 24'd6, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      hang = 1'b1;
      send(8'd3, 8'd5, 1'b1);
      get_result();
      hang = 1'b0;
      check_sum("timeout", 24'd0, 1'b0, 1'b1);
      send(8'd1, 8'd2, 1'b1); get_result(); check_sum("err_cleared", 24'd2, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_extremes();
      test_vector();
      test_back_to_back_hold();
      test_overflow();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
